// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch front end (pre-IF + IF) of the five-stage
// LoongArch pipeline.
//
// Pre-IF computes nextpc and raises a fetch request on the SRAM-like
// instruction port. IF tracks the single accepted fetch and returns the
// instruction to decode. A taken-branch cancel from decode redirects fetch
// and discards any fetch that the redirect made stale.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   ID_allowin               decode can accept an instruction this cycle
//   BR_BUS[33:0]             {br_target[31:0], br_taken, br_taken_cancel}
//   IF_to_ID_valid           IF_to_ID_BUS carries a valid instruction
//   IF_to_ID_BUS[63:0]       {if_pc[31:0], if_inst[31:0]}
//   inst_sram_req            fetch request (handshake = req && addr_ok)
//   inst_sram_wr/size/wstrb/wdata   constant read-word attributes
//   inst_sram_addr[31:0]     fetch address (nextpc)
//   inst_sram_addr_ok        request accepted
//   inst_sram_data_ok        read data returned, in request order
//   inst_sram_rdata[31:0]    instruction word
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ID_allowin,
    input  logic [33:0] BR_BUS,
    output logic        IF_to_ID_valid,
    output logic [63:0] IF_to_ID_BUS,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    logic [31:0] br_target;
    logic        br_cancel;
    logic        unused_br_taken;

    logic        started;
    logic [31:0] pc_p1;
    logic        if_vld_p1;
    logic [31:0] inst_buf_p1;
    logic        inst_buf_vld_p1;
    logic [31:0] br_buf_p0;
    logic        br_buf_vld_p0;
    logic [1:0]  discard_cnt;

    logic        handshake;
    logic        if_data_ok;
    logic        drop_data;
    logic        if_ready_go;
    logic        if_allowin;
    logic        handoff;
    logic        wait_cancel;
    logic [31:0] nextpc;

    assign br_target       = BR_BUS[33:2];
    assign unused_br_taken = BR_BUS[1];
    assign br_cancel       = BR_BUS[0];

    // ---- pre-IF: next PC and request -------------------------------------
    // A buffered redirect outranks a fresh one: it was raised while the
    // request port was stalled and must be the next accepted address.
    always_comb begin
        nextpc = pc_p1 + 32'd4;
        if (br_buf_vld_p0) begin
            nextpc = br_buf_p0;
        end else if (br_cancel) begin
            nextpc = br_target;
        end
    end

    assign handshake = inst_sram_req && inst_sram_addr_ok;

    // Returned data belongs to IF only when no stale fetch is ahead of it.
    assign if_data_ok  = inst_sram_data_ok && (discard_cnt == 2'd0);
    assign drop_data   = inst_sram_data_ok && (discard_cnt != 2'd0);
    assign if_ready_go = (inst_sram_data_ok || inst_buf_vld_p1) && (discard_cnt == 2'd0);
    assign if_allowin  = !if_vld_p1 || (if_ready_go && ID_allowin);
    assign handoff     = if_vld_p1 && if_ready_go && ID_allowin;

    // A cancel while IF still waits for its data leaves a stale response in
    // flight; it has to be counted so it can be dropped when it arrives.
    assign wait_cancel = br_cancel && if_vld_p1 && !inst_buf_vld_p1 && !if_data_ok;

    assign inst_sram_req   = started && if_allowin;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // ---- IF: outstanding fetch, instruction buffer, hand-off to ID -------
    assign IF_to_ID_valid = if_vld_p1 && if_ready_go;
    assign IF_to_ID_BUS   = {pc_p1, inst_buf_vld_p1 ? inst_buf_p1 : inst_sram_rdata};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started         <= 1'b0;
            pc_p1           <= RESET_PC - 32'd4;
            if_vld_p1       <= 1'b0;
            inst_buf_p1     <= 32'h0;
            inst_buf_vld_p1 <= 1'b0;
            br_buf_p0       <= 32'h0;
            br_buf_vld_p0   <= 1'b0;
            discard_cnt     <= 2'd0;
        end else begin
            started <= 1'b1;

            if (handshake) begin
                pc_p1 <= nextpc;
            end

            // A handshake in the cancel cycle already targets the new path.
            if (handshake) begin
                if_vld_p1 <= 1'b1;
            end else if (br_cancel || handoff) begin
                if_vld_p1 <= 1'b0;
            end

            if (br_cancel || handoff) begin
                inst_buf_vld_p1 <= 1'b0;
            end else if (if_vld_p1 && if_data_ok && !ID_allowin) begin
                inst_buf_vld_p1 <= 1'b1;
                inst_buf_p1     <= inst_sram_rdata;
            end

            if (handshake) begin
                br_buf_vld_p0 <= 1'b0;
            end else if (br_cancel) begin
                br_buf_vld_p0 <= 1'b1;
                br_buf_p0     <= br_target;
            end

            discard_cnt <= discard_cnt + {1'b0, wait_cancel} - {1'b0, drop_data};
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        ID_allowin;
    logic [33:0] BR_BUS;
    logic        IF_to_ID_valid;
    logic [63:0] IF_to_ID_BUS;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int checks;
    int failures;

    logic [32:0] ra;
    logic [64:0] ob;
    logic [32:0] exp_ra;
    logic [64:0] exp_ob;
    logic [38:0] exp_tie;

    assign ra = {inst_sram_req, inst_sram_addr};
    assign ob = {IF_to_ID_valid, IF_to_ID_BUS};

    if_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ID_allowin        (ID_allowin),
        .BR_BUS            (BR_BUS),
        .IF_to_ID_valid    (IF_to_ID_valid),
        .IF_to_ID_BUS      (IF_to_ID_BUS),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench's memory returns for a given address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5a5a_a5a5;
    endfunction

    task automatic quiet();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        ID_allowin        = 1'b1;
        BR_BUS            = 34'h0;
    endtask

    // One clock cycle: inputs applied 1 time unit after the rising edge,
    // outputs sampled 4 units after it (well before the falling edge).
    task automatic cyc(input logic aok, input logic dok, input logic [31:0] rd,
                       input logic allow, input logic cancel, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = rd;
        ID_allowin        = allow;
        BR_BUS            = {tgt, cancel, cancel};
        #3;
    endtask

    task automatic do_reset();
        quiet();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        quiet();
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (inst_sram_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", inst_sram_req); end
        checks++; if (IF_to_ID_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", IF_to_ID_valid); end
        exp_tie = {1'b0, 2'b10, 4'h0, 32'h0};
        checks++; if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== exp_tie) begin
            failures++; $display("FAIL rst_tieoff got=%h exp=%h", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}, exp_tie); end
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        checks++; if (inst_sram_req !== 1'b0) begin failures++; $display("FAIL rst_release_req got=%b exp=0", inst_sram_req); end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        exp_ra = {1'b1, 32'h1c000000};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL rst_first_req got=%h exp=%h", ra, exp_ra); end
    endtask

    task automatic test_stream();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        exp_ra = {1'b1, 32'h1c000000};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL stream_req0 got=%h exp=%h", ra, exp_ra); end
        checks++; if (IF_to_ID_valid !== 1'b0) begin failures++; $display("FAIL stream_valid0 got=%b exp=0", IF_to_ID_valid); end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, inst_of(32'h1c000000 + 32'(4 * k)), 1'b1, 1'b0, 32'h0);
            exp_ob = {1'b1, 32'h1c000000 + 32'(4 * k), inst_of(32'h1c000000 + 32'(4 * k))};
            checks++; if (ob !== exp_ob) begin failures++; $display("FAIL stream_out%0d got=%h exp=%h", k, ob, exp_ob); end
            exp_ra = {1'b1, 32'h1c000004 + 32'(4 * k)};
            checks++; if (ra !== exp_ra) begin failures++; $display("FAIL stream_req%0d got=%h exp=%h", k + 1, ra, exp_ra); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, inst_of(32'h1c000000), 1'b1, 1'b0, 32'h0);
        // data for 1c000004 arrives while decode is stalled
        cyc(1'b1, 1'b1, inst_of(32'h1c000004), 1'b0, 1'b0, 32'h0);
        checks++; if (inst_sram_req !== 1'b0) begin failures++; $display("FAIL bp_req_c0 got=%b exp=0", inst_sram_req); end
        for (int k = 1; k < 3; k++) begin
            cyc(1'b1, 1'b0, 32'hdead0000, 1'b0, 1'b0, 32'h0);
            checks++; if (inst_sram_req !== 1'b0) begin failures++; $display("FAIL bp_req_c%0d got=%b exp=0", k, inst_sram_req); end
            exp_ob = {1'b1, 32'h1c000004, inst_of(32'h1c000004)};
            checks++; if (ob !== exp_ob) begin failures++; $display("FAIL bp_hold_c%0d got=%h exp=%h", k, ob, exp_ob); end
        end
        // release: buffered instruction handed off, next request in same cycle
        cyc(1'b1, 1'b0, 32'hdead0000, 1'b1, 1'b0, 32'h0);
        exp_ob = {1'b1, 32'h1c000004, inst_of(32'h1c000004)};
        checks++; if (ob !== exp_ob) begin failures++; $display("FAIL bp_release got=%h exp=%h", ob, exp_ob); end
        exp_ra = {1'b1, 32'h1c000008};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL bp_next_req got=%h exp=%h", ra, exp_ra); end
        cyc(1'b0, 1'b1, inst_of(32'h1c000008), 1'b1, 1'b0, 32'h0);
        exp_ob = {1'b1, 32'h1c000008, inst_of(32'h1c000008)};
        checks++; if (ob !== exp_ob) begin failures++; $display("FAIL bp_after got=%h exp=%h", ob, exp_ob); end
    endtask

    task automatic test_cancel_outstanding();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, inst_of(32'h1c000000), 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, inst_of(32'h1c000004), 1'b1, 1'b0, 32'h0);
        // fetch of 1c000008 outstanding; cancel arrives before its data
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000100);
        checks++; if ({inst_sram_req, IF_to_ID_valid} !== 2'b00) begin
            failures++; $display("FAIL co_cancel_cycle got=%b exp=00", {inst_sram_req, IF_to_ID_valid}); end
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        exp_ra = {1'b1, 32'h1c000100};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL co_target_req got=%h exp=%h", ra, exp_ra); end
        // stale data for 1c000008 returns late and must be dropped
        cyc(1'b1, 1'b1, inst_of(32'h1c000008), 1'b1, 1'b0, 32'h0);
        checks++; if ({IF_to_ID_valid, inst_sram_req} !== 2'b00) begin
            failures++; $display("FAIL co_stale_drop got=%b exp=00", {IF_to_ID_valid, inst_sram_req}); end
        cyc(1'b1, 1'b1, inst_of(32'h1c000100), 1'b1, 1'b0, 32'h0);
        exp_ob = {1'b1, 32'h1c000100, inst_of(32'h1c000100)};
        checks++; if (ob !== exp_ob) begin failures++; $display("FAIL co_target_out got=%h exp=%h", ob, exp_ob); end
        exp_ra = {1'b1, 32'h1c000104};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL co_next_req got=%h exp=%h", ra, exp_ra); end
    endtask

    task automatic test_cancel_addr_stall();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, inst_of(32'h1c000000), 1'b1, 1'b0, 32'h0);
        // branch at 1c000004 resolves while the slave refuses addresses
        cyc(1'b0, 1'b1, inst_of(32'h1c000004), 1'b1, 1'b1, 32'h1c000200);
        exp_ra = {1'b1, 32'h1c000200};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL as_cancel_req got=%h exp=%h", ra, exp_ra); end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL as_buffered_req got=%h exp=%h", ra, exp_ra); end
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL as_accepted_req got=%h exp=%h", ra, exp_ra); end
        cyc(1'b0, 1'b1, inst_of(32'h1c000200), 1'b1, 1'b0, 32'h0);
        exp_ob = {1'b1, 32'h1c000200, inst_of(32'h1c000200)};
        checks++; if (ob !== exp_ob) begin failures++; $display("FAIL as_target_out got=%h exp=%h", ob, exp_ob); end
        exp_ra = {1'b1, 32'h1c000204};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL as_next_req got=%h exp=%h", ra, exp_ra); end
    endtask

    task automatic test_cancel_handshake();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        // cancel in the same cycle as an accepted request
        cyc(1'b1, 1'b1, inst_of(32'h1c000000), 1'b1, 1'b1, 32'h1c000300);
        exp_ra = {1'b1, 32'h1c000300};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL ch_req got=%h exp=%h", ra, exp_ra); end
        cyc(1'b0, 1'b1, inst_of(32'h1c000300), 1'b1, 1'b0, 32'h0);
        exp_ob = {1'b1, 32'h1c000300, inst_of(32'h1c000300)};
        checks++; if (ob !== exp_ob) begin failures++; $display("FAIL ch_out got=%h exp=%h", ob, exp_ob); end
        exp_ra = {1'b1, 32'h1c000304};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL ch_next_req got=%h exp=%h", ra, exp_ra); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, inst_of(32'h1c000000), 1'b1, 1'b0, 32'h0);
        quiet();
        resetn = 1'b0;
        #1;
        checks++; if ({inst_sram_req, IF_to_ID_valid} !== 2'b00) begin
            failures++; $display("FAIL mid_rst_out got=%b exp=00", {inst_sram_req, IF_to_ID_valid}); end
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        exp_ra = {1'b1, 32'h1c000000};
        checks++; if (ra !== exp_ra) begin failures++; $display("FAIL mid_restart_req got=%h exp=%h", ra, exp_ra); end
        checks++; if (IF_to_ID_valid !== 1'b0) begin failures++; $display("FAIL mid_restart_valid got=%b exp=0", IF_to_ID_valid); end
        cyc(1'b1, 1'b1, inst_of(32'h1c000000), 1'b1, 1'b0, 32'h0);
        exp_ob = {1'b1, 32'h1c000000, inst_of(32'h1c000000)};
        checks++; if (ob !== exp_ob) begin failures++; $display("FAIL mid_restart_out got=%h exp=%h", ob, exp_ob); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_cancel_outstanding();
        test_cancel_addr_stall();
        test_cancel_handshake();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
